// File: rtl/configure.sv
// configure: SoC-wide timing and sizing constants shared by the UART blocks.
//   clks_per_bit   - bit period minus one, in clk_pll cycles
//   prefetch_depth - receive buffer depth (power of two)
package configure;
    localparam int unsigned clks_per_bit   = 433;
    localparam int unsigned prefetch_depth = 4;
endpackage

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
//   uart_rx_state_t - receiver FSM states
//   uart_data_bits  - payload bits per frame
//   uart_half_bit   - clocks from start-edge detection to mid-start-bit
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int unsigned uart_data_bits = 8;
    localparam int unsigned uart_half_bit  = configure::clks_per_bit / 2;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer FIFO (used when UART_RX_FIFO_EN is defined).
// Ports:
//   clock, reset     - clock, synchronous active-high reset
//   push, push_data  - write request and byte; accepted if not full, or
//                      if a pop happens in the same cycle
//   pop              - remove head entry (ignored when empty)
//   head             - entry at the read pointer (registered storage)
//   full, empty      - occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte delivery.
// Ports:
//   clock     - clk_pll domain clock
//   reset     - synchronous, active-high
//   rx        - asynchronous serial input, idle high
//   rx_data   - byte at buffer head
//   rx_valid  - rx_data holds an unread byte
//   rx_ready  - consumer accepts head when rx_valid && rx_ready
//   frame_err - one-cycle pulse: stop bit sampled low
//   overrun   - one-cycle pulse: good byte dropped, buffer full
// Build option UART_RX_FIFO_EN: FIFO_DEPTH-entry FIFO buffer; otherwise a
// single holding register.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = configure::clks_per_bit,
    parameter int unsigned FIFO_DEPTH   = configure::prefetch_depth
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int unsigned P  = CLKS_PER_BIT + 1;
    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(P);

    localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
    localparam logic [CW-1:0] P_LAST   = CW'(P - 1);
    localparam logic [2:0]    LAST_BIT = 3'(uart_data_bits - 1);

    uart_rx_state_t state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [2:0]     bit_idx, bit_next;
    logic [7:0]     shift, shift_next;
    logic           rx_meta, rx_s;
    logic           push_req, ferr_set;
    logic           pop, buf_full;

    // Synchronizer flops reset high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        push_req   = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == H_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == P_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_idx == LAST_BIT) state_next = STOP;
                    else                     bit_next   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == P_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
    logic buf_empty;

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_req),
        .push_data(shift),
        .pop      (pop),
        .head     (rx_data),
        .full     (buf_full),
        .empty    (buf_empty)
    );

    assign rx_valid = !buf_empty;
`else
    logic [7:0] hold;
    logic       hold_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (push_req && (!hold_valid || pop)) begin
            hold       <= shift;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign rx_data  = hold;
    assign rx_valid = hold_valid;
    assign buf_full = hold_valid;
`endif

    // A pop in the push cycle frees a slot, so only an un-popped full buffer overruns.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= push_req && buf_full && !pop;
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the SoC's memory-mapped UART. It recovers 8N1 frames from the asynchronous `rx` pin using the same bit timing as the transmit side (`clks_per_bit` from `configure`). It delivers each received byte over a valid/ready handshake to the UART register interface, and flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, default `configure::clks_per_bit` (433): bit period is `CLKS_PER_BIT+1` clocks (434).
- `FIFO_DEPTH`, default `configure::prefetch_depth` (4): receive buffer entries, power of two. Used only with `UART_RX_FIFO_EN`.
- `clock`, in, 1: single clock (the `clk_pll` domain).
- `reset`, in, 1: synchronous, active-high.
- `rx`, in, 1: asynchronous serial line, idle high.
- `rx_data`, out, 8: byte at the buffer head; reset value 0.
- `rx_valid`, out, 1: `rx_data` is valid; reset value 0.
- `rx_ready`, in, 1: consumer accepts the head byte when `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low; reset value 0.
- `overrun`, out, 1: one-cycle pulse when a good byte is dropped because the buffer is full; reset value 0.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1, so reset never creates a false start.
- Definitions: H = `CLKS_PER_BIT/2` (216), P = `CLKS_PER_BIT+1` (434). One down/up counter of width `$clog2(P)`.
- **IDLE**
  - Synchronized rx = 0 → START; counter cleared.
- **START**
  - After H clocks, sample the line.
  - 1 → false start, return to IDLE, nothing reported.
  - 0 → DATA, with bit index 0.
- **DATA**
  - Sample every P clocks, LSB first, into a shift register.
  - After bit 7 → STOP.
- **STOP**
  - Sample after P clocks.
  - 1 → push the byte; go to IDLE immediately, so back-to-back frames are received.
  - 0 → pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK**
  - Wait for synchronized rx = 1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- **Push with the buffer full**
  - Pulse `overrun` and discard the new byte; buffered bytes are unchanged.
  - Exception: if a pop (`rx_valid && rx_ready`) happens in the same cycle, the push succeeds and there is no overrun.
- **Reset mid-frame:** state to IDLE, buffer emptied, all outputs return to their reset values in the next cycle.
- `rx_data` is stable while `rx_valid && !rx_ready`.

## Timing
- Let T be the first cycle the synchronized rx is 0. T is 2 clocks after the pin edge.
- Start sample at T+H. Data bit i is sampled at T+H+(i+1)·P. Stop bit is sampled at T+H+9P.
- `rx_valid` rises at T+H+9P+1, which is 4123 clocks after T with the default parameters.
- `frame_err` and `overrun` assert at T+H+9P+1, for one cycle.
- Pop is effective on the handshake edge. The next entry is presented, or `rx_valid` falls, in the following cycle. There are no combinational paths from `rx_ready` to any output.

## Configuration
- **`UART_RX_FIFO_EN` defined:** buffer is a `FIFO_DEPTH`-entry FIFO.
  - Read/write pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap modulo 2·depth.
  - Full = MSBs differ with the low bits equal; empty = pointers equal.
- **`UART_RX_FIFO_EN` undefined:** buffer is a single holding register plus a valid flag. Overrun occurs on the second unread byte.
- Handshake and timing are identical in both builds.

## Structure
- `configure` holds `clks_per_bit` and the buffer depth.
- A shared package holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - constants `uart_data_bits = 8` and `uart_half_bit = clks_per_bit/2`.
- Natural sub-module: `uart_rx_fifo`, the buffer with push/pop/full/empty. It is instantiated under the macro, with the single register otherwise.

## Test plan
- Send 0xA5 at P=434 clocks/bit → one `rx_valid` with `rx_data`=0xA5 at T+4123; no error pulses.
- Send a 100-clock low glitch on idle `rx` → false start, no `rx_valid`, no `frame_err`, state back to IDLE.
- Send 0x3C with the stop bit low, then hold `rx` low for 20 bit times → exactly one `frame_err` pulse, no byte; next frame 0x55 received correctly.
- Hold `rx_ready`=0 and send 0x01..0x06 → FIFO build yields 0x01..0x04 then 2 `overrun` pulses; non-FIFO build yields 0x01 and 5 `overrun` pulses.
- Buffer full, with `rx_ready`=1 asserted exactly in the push cycle → no `overrun`, and the new byte is delivered in order.
- Assert `reset` during data bit 3 of 0xFF → outputs 0 next cycle, no partial byte; the following frame 0x81 is received correctly.
